// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch (I) and data access (D).
// Optional macro ARB_FAIR_EN bounds consecutive D grants while I waits (MAX_D_STREAK).
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic [DW-1:0]   i_rdata,
  output logic            i_done,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic [DW-1:0]   d_rdata,
  output logic            d_done,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ready
);

  localparam int BW = DW / 8;

  typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2, RESP = 2'd3} state_e;

  state_e          state_q, state_d;
  logic            pick_i, pick_d;
  logic            force_i;
  logic            mem_req_q, mem_we_q, i_done_q, d_done_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q, i_rdata_q, d_rdata_q;
  logic [BW-1:0]   mem_be_q;

`ifdef ARB_FAIR_EN
  localparam int SW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  logic [SW-1:0] streak_q;

  assign force_i = i_req && (streak_q == SW'(MAX_D_STREAK));

  // D-grant streak: counts D grants made while I was waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= '0;
    end else if (pick_i) begin
      streak_q <= '0;
    end else if (pick_d) begin
      streak_q <= i_req ? (streak_q + SW'(1)) : '0;
    end else begin
      streak_q <= streak_q;
    end
  end
`else
  assign force_i = 1'b0;
`endif

  // Next-state logic; requests are only sampled in IDLE
  always_comb begin
    state_d = state_q;
    pick_i  = 1'b0;
    pick_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req && !force_i) begin
          pick_d  = 1'b1;
          state_d = GNT_D;
        end else if (i_req) begin
          pick_i  = 1'b1;
          state_d = GNT_I;
        end else begin
          state_d = IDLE;
        end
      end
      GNT_I, GNT_D: begin
        if (mem_ready) begin
          state_d = RESP;
        end else begin
          state_d = state_q;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, memory-side command and completion registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= (state_d == GNT_I) || (state_d == GNT_D);
      i_done_q  <= (state_q == GNT_I) && mem_ready;
      d_done_q  <= (state_q == GNT_D) && mem_ready;
      if (pick_d) begin
        mem_we_q    <= d_we;
        mem_addr_q  <= d_addr;
        mem_wdata_q <= d_wdata;
        mem_be_q    <= d_be;
      end else if (pick_i) begin
        mem_we_q    <= 1'b0;
        mem_addr_q  <= i_addr;
        mem_wdata_q <= '0;
        mem_be_q    <= '1;
      end else begin
        mem_we_q    <= mem_we_q;
        mem_addr_q  <= mem_addr_q;
        mem_wdata_q <= mem_wdata_q;
        mem_be_q    <= mem_be_q;
      end
      // D writes leave the last load value visible on d_rdata
      if ((state_q == GNT_I) && mem_ready) begin
        i_rdata_q <= mem_rdata;
      end else begin
        i_rdata_q <= i_rdata_q;
      end
      if ((state_q == GNT_D) && mem_ready && !mem_we_q) begin
        d_rdata_q <= mem_rdata;
      end else begin
        d_rdata_q <= d_rdata_q;
      end
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, BW = 4, MAXS = 4;
`ifdef ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, i_req, i_done, d_req, d_we, d_done, mem_req, mem_we, mem_ready;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic [DW-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
  logic [BW-1:0] d_be, mem_be;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int tests = 0;
  int fails = 0;

  // model: phase 0 = waiting for a grant, 1 = access outstanding, 2 = completion cycle
  int            m_phase, m_streak;
  bit            m_isd, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_irdata, m_drdata;
  logic [BW-1:0] m_be;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_streak = 0; m_isd = 1'b0; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; m_be = '0; m_irdata = '0; m_drdata = '0;
  endtask

  // advance the model across the coming clock edge using the inputs now driven
  task automatic model_step();
    bit favour_i;
    case (m_phase)
      0: begin
        favour_i = FAIR && i_req && (m_streak == MAXS);
        if (d_req && !favour_i) begin
          m_phase = 1; m_isd = 1'b1; m_we = d_we; m_addr = d_addr;
          m_wdata = d_wdata; m_be = d_be;
          m_streak = i_req ? m_streak + 1 : 0;
        end else if (i_req) begin
          m_phase = 1; m_isd = 1'b0; m_we = 1'b0; m_addr = i_addr; m_be = 4'hF;
          m_streak = 0;
        end
      end
      1: if (mem_ready) begin
        if (!m_isd) m_irdata = mem_rdata;
        else if (!m_we) m_drdata = mem_rdata;
        m_phase = 2;
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic compare();
    chk("mem_req", mem_req, (m_phase == 1));
    chk("i_done", i_done, (m_phase == 2) && !m_isd);
    chk("d_done", d_done, (m_phase == 2) && m_isd);
    chk("i_rdata", i_rdata, m_irdata);
    chk("d_rdata", d_rdata, m_drdata);
    if (m_phase == 1) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", mem_we, m_we);
      chk("mem_be", mem_be, m_be);
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0;
    d_wdata = '0; d_be = '0; mem_rdata = '0; mem_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int ngrant;
    bit got_d [10];
    bit exp_d [10];

    do_reset();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_i_done", i_done, 1'b0);
    chk("rst_d_done", d_done, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_i_rdata", i_rdata, 32'h0);

    // single fetch with memory ready immediately
    i_req = 1'b1; i_addr = 32'h0000_0040; mem_ready = 1'b1; mem_rdata = 32'h2108_0001;
    tick();
    chk("t1_mem_req", mem_req, 1'b1);
    chk("t1_mem_addr", mem_addr, 32'h40);
    chk("t1_mem_be", mem_be, 4'hF);
    chk("t1_mem_we", mem_we, 1'b0);
    tick();
    chk("t1_i_done", i_done, 1'b1);
    chk("t1_i_rdata", i_rdata, 32'h2108_0001);
    i_req = 1'b0;
    tick();
    chk("t1_done_pulse", i_done, 1'b0);

    // both request: D first, then I
    i_req = 1'b1; i_addr = 32'h44; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000;
    mem_rdata = 32'h0D0D_0D0D;
    tick();
    chk("t2_d_first", mem_addr, 32'h1000);
    tick();
    chk("t2_d_done", d_done, 1'b1);
    chk("t2_d_rdata", d_rdata, 32'h0D0D_0D0D);
    d_req = 1'b0; mem_rdata = 32'h1111_2222;
    tick();
    tick();
    chk("t2_i_second", mem_addr, 32'h44);
    tick();
    chk("t2_i_done", i_done, 1'b1);
    chk("t2_i_rdata", i_rdata, 32'h1111_2222);
    i_req = 1'b0;
    tick();

    // D write with mem_ready delayed
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF; d_be = 4'h3;
    mem_ready = 1'b0;
    tick();
    for (int k = 1; k <= 5; k++) begin
      chk("t3_mem_req_held", mem_req, 1'b1);
      chk("t3_mem_we", mem_we, 1'b1);
      chk("t3_mem_be", mem_be, 4'h3);
      chk("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      if (k == 5) mem_ready = 1'b1;
      tick();
    end
    chk("t3_d_done", d_done, 1'b1);
    chk("t3_d_rdata_kept", d_rdata, 32'h0D0D_0D0D);
    d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    tick();

    // mem_ready while idle is ignored
    mem_ready = 1'b1;
    repeat (3) begin
      tick();
      chk("t6_mem_req", mem_req, 1'b0);
      chk("t6_dones", {i_done, d_done}, 2'b00);
    end
    mem_ready = 1'b0;

    // reset asserted in GNT_D
    d_req = 1'b1; d_addr = 32'h3000;
    tick();
    chk("t4_in_gnt", mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_async_mem_req", mem_req, 1'b0);
    chk("t4_async_dones", {i_done, d_done}, 2'b00);
    model_reset();
    d_req = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk("t4_no_stale_done", {i_done, d_done}, 2'b00);
    end
    mem_ready = 1'b0;

    // grant order with both requests held high
    do_reset();
    for (int k = 0; k < 10; k++) exp_d[k] = !(FAIR && (k % 5 == 4));
    i_req = 1'b1; i_addr = 32'h44; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000;
    mem_ready = 1'b1;
    ngrant = 0;
    for (int c = 0; c < 60 && ngrant < 10; c++) begin
      tick();
      if (mem_req === 1'b1) begin
        got_d[ngrant] = (mem_addr == 32'h1000);
        ngrant++;
      end
    end
    chk("t5_grant_count", ngrant, 10);
    for (int k = 0; k < ngrant; k++) chk("t5_grant_order", got_d[k], exp_d[k]);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (m_phase == 1) mem_ready = ($urandom_range(2) == 0);
      else mem_ready = ($urandom_range(4) == 0);
      mem_rdata = $urandom;
      tick();
      if (m_phase == 2 && !m_isd) i_req = 1'b0;
      else if (!i_req && $urandom_range(2) == 0) begin
        i_req = 1'b1; i_addr = $urandom;
      end
      if (m_phase == 2 && m_isd) d_req = 1'b0;
      else if (!d_req && $urandom_range(2) == 0) begin
        d_req = 1'b1; d_we = $urandom_range(1); d_addr = $urandom;
        d_wdata = $urandom; d_be = 4'($urandom_range(15));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
